alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; even, >= 8.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width taken from b[SHW-1:0].
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, synchronous and active-low.
REQ-005 start  in  1  request; sampled only while busy=0.
REQ-006 op  in  4  operation code (encodings in alu_pkg).
REQ-007 a, b  in  WIDTH each  operands, captured on an accepted start.
REQ-008 busy  out  1  high from the cycle after accept until the done cycle, inclusive.
REQ-009 done  out  1  one-cycle pulse; results valid in that cycle and held afterwards.
REQ-010 result_lo, result_hi  out  WIDTH each  low/high result words.
REQ-011 dbz  out  1  divide-by-zero flag, valid with done.
REQ-012 illegal  out  1  unused opcode flag, valid with done.

Function
REQ-013 Ops: AND, OR, NOT(a), NEG(-a, two's complement), ADD, SUB(a-b), SHL, SHR, SRA, ROL, ROR, MUL (signed), DIV (signed); all other codes are illegal.
REQ-014 Single-cycle ops: start accepted in cycle N -> done=1 in N+1; result_hi=0.
REQ-015 ADD/SUB: result_lo = low WIDTH bits; result_hi[0] = carry out (ADD) or borrow (SUB); other result_hi bits 0.
REQ-016 Shifts/rotates use b[SHW-1:0]; a shift amount of 0 returns a unchanged.
REQ-017 MUL: full 2*WIDTH signed product, {result_hi,result_lo}; iterative, one partial product per cycle; done in cycle N+WIDTH+2.
REQ-018 DIV: quotient -> result_lo, remainder -> result_hi; quotient truncates toward zero, remainder takes the sign of a; iterative, done in cycle N+WIDTH+2.
REQ-019 DIV with b=0: done in N+1, dbz=1, result_lo = all ones, result_hi = a; no iteration.
REQ-020 DIV of most-negative by -1: result_lo = most-negative, result_hi = 0, dbz=0.
REQ-021 Illegal op: done in N+1, illegal=1, both results 0.
REQ-022 FSM states: IDLE -> (accepted start, single op) DONE; IDLE -> (MUL/DIV, b!=0 for DIV) RUN; RUN -> (WIDTH iterations) FIX (sign correction) -> DONE; DONE -> IDLE.
REQ-023 start is ignored while busy=1 or during the done cycle; a start in the cycle after done is accepted (back-to-back throughput).
REQ-024 dbz and illegal hold until the next done; results hold until the next done.

Reset
REQ-025 rst_n=0 at a rising edge: FSM -> IDLE; busy, done, dbz, illegal = 0; result_lo, result_hi = 0.
REQ-026 Reset during RUN/FIX aborts the operation; no done pulse is produced for it.
REQ-027 start asserted in the same cycle as rst_n=0 is dropped.

Structure
REQ-028 Package alu_pkg holds the op encodings (typedef enum, 4 bits), the FSM state typedef, and iteration-count width.
REQ-029 Sub-module alu_muldiv_iter (shift-add multiplier plus restoring divider sharing one WIDTH+1 adder) holds the iterative datapath; the single-cycle ops and the FSM live in alu_seq.

Verification
REQ-030 WIDTH=32: AND a=0xF0F0_00FF, b=0x0FF0_FF0F -> done at N+1, result_lo=0x00F0_000F, result_hi=0.
REQ-031 MUL a=-3 (0xFFFF_FFFD), b=7 -> done at N+34, {hi,lo}=0xFFFF_FFFF_FFFF_FFEB, busy high N+1..N+34.
REQ-032 DIV a=-7, b=2 -> lo=0xFFFF_FFFD (-3), hi=0xFFFF_FFFF (-1); DIV a=5, b=0 -> N+1, dbz=1, lo=0xFFFF_FFFF, hi=5.
REQ-033 ROR a=0x8000_0001, b=1 -> lo=0xC000_0000; SRA a=0x8000_0000, b=31 -> lo=0xFFFF_FFFF; ADD 0xFFFF_FFFF+1 -> lo=0, hi=1.
REQ-034 MUL started, rst_n=0 at N+10 -> no done, all outputs 0 at N+11; new start at N+12 completes normally; start during busy ignored.
REQ-035 WIDTH=8 random MUL/DIV/ops sweep against a reference model, including op=0xF -> illegal=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states, counter sizing.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND = 4'h0,
        OP_OR  = 4'h1,
        OP_NOT = 4'h2,
        OP_NEG = 4'h3,
        OP_ADD = 4'h4,
        OP_SUB = 4'h5,
        OP_SHL = 4'h6,
        OP_SHR = 4'h7,
        OP_SRA = 4'h8,
        OP_ROL = 4'h9,
        OP_ROR = 4'hA,
        OP_MUL = 4'hB,
        OP_DIV = 4'hC
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } alu_state_e;

    // Iteration counter runs 0..width-1
    function automatic int unsigned iter_cnt_w(input int unsigned width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative signed multiply / divide on magnitudes with a shared WIDTH+1 adder.
// MUL: shift-add, {hi_q,lo_q} accumulates the product.
// DIV: restoring, hi_q holds the partial remainder, lo_q shifts dividend out / quotient in.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             is_div_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] fix_lo_c_o,
    output logic [WIDTH-1:0] fix_hi_c_o
);

    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic [WIDTH-1:0]   opnd_q;
    logic               div_q;
    logic               neg_lo_q;
    logic               neg_hi_q;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     add_a;
    logic [WIDTH:0]     add_b;
    logic               add_cin;
    logic [WIDTH+1:0]   add_sum;
    logic [2*WIDTH-1:0] prod_fix;

    assign a_mag   = a_i[WIDTH-1] ? -a_i : a_i;
    assign b_mag   = b_i[WIDTH-1] ? -b_i : b_i;
    assign add_sum = {1'b0, add_a} + {1'b0, add_b} + (WIDTH+2)'(add_cin);

    // Shared adder operands: trial subtract for DIV, conditional add for MUL
    always_comb begin
        add_a   = {1'b0, hi_q};
        add_b   = '0;
        add_cin = 1'b0;
        if (div_q) begin
            add_a   = {hi_q, lo_q[WIDTH-1]};
            add_b   = ~{1'b0, opnd_q};
            add_cin = 1'b1;
        end else if (lo_q[0]) begin
            add_b   = {1'b0, opnd_q};
        end
    end

    // Operand capture and one iteration per step
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            div_q    <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
        end else if (load_i) begin
            hi_q     <= '0;
            lo_q     <= a_mag;
            opnd_q   <= b_mag;
            div_q    <= is_div_i;
            neg_lo_q <= a_i[WIDTH-1] ^ b_i[WIDTH-1];
            neg_hi_q <= is_div_i & a_i[WIDTH-1];
        end else if (step_i) begin
            if (div_q) begin
                // carry out of the trial subtract means the divisor fits
                hi_q <= add_sum[WIDTH+1] ? add_sum[WIDTH-1:0]
                                         : {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
                lo_q <= {lo_q[WIDTH-2:0], add_sum[WIDTH+1]};
            end else begin
                hi_q <= add_sum[WIDTH:1];
                lo_q <= {add_sum[0], lo_q[WIDTH-1:1]};
            end
        end
    end

    // Sign correction of the magnitude result
    always_comb begin
        prod_fix   = neg_lo_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        fix_lo_c_o = prod_fix[WIDTH-1:0];
        fix_hi_c_o = prod_fix[2*WIDTH-1:WIDTH];
        if (div_q) begin
            fix_lo_c_o = neg_lo_q ? -lo_q : lo_q;
            fix_hi_c_o = neg_hi_q ? -hi_q : hi_q;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith/shift ops plus iterative MUL/DIV.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             dbz,
    output logic             illegal
);

    localparam int unsigned      CNT_W = iter_cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    alu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             dbz_q, dbz_d;
    logic             ill_q, ill_d;

    logic             go_iter;
    logic             accept;
    logic [SHW-1:0]   sh;
    logic [SHW:0]     inv_sh;
    logic [WIDTH:0]   add_ext;
    logic [WIDTH:0]   sub_ext;
    logic [WIDTH-1:0] sgl_lo;
    logic [WIDTH-1:0] sgl_hi;
    logic             sgl_dbz;
    logic             sgl_ill;
    logic [WIDTH-1:0] md_lo;
    logic [WIDTH-1:0] md_hi;

    assign go_iter = (op == OP_MUL) || ((op == OP_DIV) && (b != '0));
    assign accept  = (state_q == ST_IDLE) && start;
    assign sh      = b[SHW-1:0];
    assign inv_sh  = (SHW+1)'(WIDTH) - {1'b0, sh};
    assign add_ext = {1'b0, a} + {1'b0, b};
    assign sub_ext = {1'b0, a} - {1'b0, b};

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (accept && go_iter),
        .is_div_i   (op == OP_DIV),
        .step_i     (state_q == ST_RUN),
        .a_i        (a),
        .b_i        (b),
        .fix_lo_c_o (md_lo),
        .fix_hi_c_o (md_hi)
    );

    // Single-cycle operation results, including the divide-by-zero shortcut
    always_comb begin
        sgl_lo  = '0;
        sgl_hi  = '0;
        sgl_dbz = 1'b0;
        sgl_ill = 1'b0;
        case (op)
            OP_AND: sgl_lo = a & b;
            OP_OR:  sgl_lo = a | b;
            OP_NOT: sgl_lo = ~a;
            OP_NEG: sgl_lo = -a;
            OP_ADD: begin
                sgl_lo = add_ext[WIDTH-1:0];
                sgl_hi = WIDTH'(add_ext[WIDTH]);
            end
            OP_SUB: begin
                sgl_lo = sub_ext[WIDTH-1:0];
                sgl_hi = WIDTH'(sub_ext[WIDTH]);
            end
            OP_SHL: sgl_lo = a << sh;
            OP_SHR: sgl_lo = a >> sh;
            OP_SRA: sgl_lo = WIDTH'($signed(a) >>> sh);
            OP_ROL: sgl_lo = (a << sh) | (a >> inv_sh);
            OP_ROR: sgl_lo = (a >> sh) | (a << inv_sh);
            OP_DIV: begin
                sgl_dbz = 1'b1;
                sgl_lo  = '1;
                sgl_hi  = a;
            end
            OP_MUL: ;
            default: sgl_ill = 1'b1;
        endcase
    end

    // State and iteration counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: iterative ops spend WIDTH cycles in RUN, one in FIX
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (start) state_d = go_iter ? ST_RUN : ST_DONE;
            end
            ST_RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) state_d = ST_FIX;
            end
            ST_FIX:  state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output next values: flags follow the next state, results load on entering DONE
    always_comb begin
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
        lo_d   = lo_q;
        hi_d   = hi_q;
        dbz_d  = dbz_q;
        ill_d  = ill_q;
        if ((state_q == ST_IDLE) && (state_d == ST_DONE)) begin
            lo_d  = sgl_lo;
            hi_d  = sgl_hi;
            dbz_d = sgl_dbz;
            ill_d = sgl_ill;
        end else if (state_q == ST_FIX) begin
            lo_d  = md_lo;
            hi_d  = md_hi;
            dbz_d = 1'b0;
            ill_d = 1'b0;
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            lo_q   <= '0;
            hi_q   <= '0;
            dbz_q  <= 1'b0;
            ill_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            lo_q   <= lo_d;
            hi_q   <= hi_d;
            dbz_q  <= dbz_d;
            ill_q  <= ill_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result_lo = lo_q;
    assign result_hi = hi_q;
    assign dbz       = dbz_q;
    assign illegal   = ill_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed WIDTH=32 cases plus a random WIDTH=8 sweep,
// both checked every cycle against a latency/arithmetic reference model.
module tb_alu_seq;
    import alu_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst32_n, start32, busy32, done32, dbz32, ill32;
    logic [3:0]  op32;
    logic [31:0] a32, b32, lo32, hi32;

    logic        rst8_n, start8, busy8, done8, dbz8, ill8;
    logic [3:0]  op8;
    logic [7:0]  a8, b8, lo8, hi8;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    alu_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst32_n), .start(start32), .op(op32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .result_lo(lo32), .result_hi(hi32),
        .dbz(dbz32), .illegal(ill32)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst8_n), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result_lo(lo8), .result_hi(hi8),
        .dbz(dbz8), .illegal(ill8)
    );

    typedef struct packed {
        int          k;
        int          lat;
        logic [63:0] lo, hi, plo, phi;
        bit          dbz, ill, pdbz, pill, busy, done;
    } mst_t;

    mst_t m32, m8;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Arithmetic reference: what one operation must produce, and its latency
    function automatic void model(input int w, input logic [3:0] op,
                                  input longint unsigned a, input longint unsigned b,
                                  output longint unsigned lo, output longint unsigned hi,
                                  output bit dbz, output bit ill, output int lat);
        longint unsigned mask, u;
        longint          sa, sb, s;
        int              sh;
        mask = (64'd1 << w) - 64'd1;
        sa   = a[w-1] ? longint'(a | ~mask) : longint'(a);
        sb   = b[w-1] ? longint'(b | ~mask) : longint'(b);
        sh   = int'(b & 64'(w - 1));
        lo = 0; hi = 0; dbz = 0; ill = 0; lat = 1;
        case (op)
            OP_AND: lo = a & b;
            OP_OR:  lo = a | b;
            OP_NOT: lo = ~a & mask;
            OP_NEG: lo = (-a) & mask;
            OP_ADD: begin u = a + b; lo = u & mask; hi = (u >> w) & 64'd1; end
            OP_SUB: begin lo = (a - b) & mask; hi = (a < b) ? 64'd1 : 64'd0; end
            OP_SHL: lo = (a << sh) & mask;
            OP_SHR: lo = a >> sh;
            OP_SRA: begin s = sa >>> sh; u = s; lo = u & mask; end
            OP_ROL: lo = ((a << sh) | (a >> (w - sh))) & mask;
            OP_ROR: lo = ((a >> sh) | (a << (w - sh))) & mask;
            OP_MUL: begin
                s = sa * sb; u = s;
                lo = u & mask; hi = (u >> w) & mask; lat = w + 2;
            end
            OP_DIV: begin
                if (b == 0) begin
                    dbz = 1; lo = mask; hi = a;
                end else begin
                    s = sa / sb; u = s; lo = u & mask;
                    s = sa % sb; u = s; hi = u & mask;
                    lat = w + 2;
                end
            end
            default: ill = 1;
        endcase
    endfunction

    // Cycle view: k counts cycles since accept, done when k reaches the latency
    function automatic mst_t mstep(input mst_t s, input bit rstn, input bit st,
                                   input logic [3:0] op, input longint unsigned a,
                                   input longint unsigned b, input int w);
        mst_t n;
        longint unsigned plo, phi;
        bit pdbz, pill;
        int lat;
        n = s;
        if (!rstn) begin
            n = '0;
            return n;
        end
        if (s.k == 0) begin
            if (st) begin
                model(w, op, a, b, plo, phi, pdbz, pill, lat);
                n.plo = plo; n.phi = phi; n.pdbz = pdbz; n.pill = pill;
                n.lat = lat; n.k = 1;
            end
        end else if (s.k == s.lat) begin
            n.k = 0;
        end else begin
            n.k = s.k + 1;
        end
        n.busy = (n.k != 0);
        n.done = (n.k != 0) && (n.k == n.lat);
        if (n.done) begin
            n.lo = n.plo; n.hi = n.phi; n.dbz = n.pdbz; n.ill = n.pill;
        end
        return n;
    endfunction

    // Advance the reference on every rising edge
    always @(posedge clk) begin
        cyc <= cyc + 1;
        m32 <= mstep(m32, rst32_n, start32, op32, 64'(a32), 64'(b32), 32);
        m8  <= mstep(m8,  rst8_n,  start8,  op8,  64'(a8),  64'(b8),  8);
    end

    // Compare both DUTs against the reference each cycle, away from the edge
    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("busy32", 64'(busy32), 64'(m32.busy));
            chk("done32", 64'(done32), 64'(m32.done));
            chk("lo32",   64'(lo32),   m32.lo);
            chk("hi32",   64'(hi32),   m32.hi);
            chk("dbz32",  64'(dbz32),  64'(m32.dbz));
            chk("ill32",  64'(ill32),  64'(m32.ill));
            chk("busy8",  64'(busy8),  64'(m8.busy));
            chk("done8",  64'(done8),  64'(m8.done));
            chk("lo8",    64'(lo8),    m8.lo);
            chk("hi8",    64'(hi8),    m8.hi);
            chk("dbz8",   64'(dbz8),   64'(m8.dbz));
            chk("ill8",   64'(ill8),   64'(m8.ill));
        end
    end

    // One directed WIDTH=32 operation with hand-computed expectations
    task automatic run32(input string nm, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] elo, input logic [31:0] ehi,
                         input bit edbz, input bit eill, input int elat);
        longint unsigned mlo, mhi;
        bit  mdbz, mill;
        int  mlat, c0, n, nbusy;
        model(32, op, 64'(a), 64'(b), mlo, mhi, mdbz, mill, mlat);
        chk({"model_lo_", nm},  mlo, 64'(elo));
        chk({"model_hi_", nm},  mhi, 64'(ehi));
        chk({"model_lat_", nm}, 64'(mlat), 64'(elat));
        @(negedge clk);
        n = 0;
        while (busy32 && n < 100) begin
            @(negedge clk);
            n++;
        end
        start32 = 1'b1; op32 = op; a32 = a; b32 = b; c0 = cyc;
        @(negedge clk);
        start32 = 1'b0;
        n = 0; nbusy = 0;
        while (!done32 && n < 100) begin
            if (busy32) nbusy++;
            start32 = 1'($urandom_range(0, 1));
            op32 = 4'($urandom); a32 = $urandom; b32 = $urandom;
            @(negedge clk);
            n++;
        end
        start32 = 1'b0;
        if (busy32) nbusy++;
        chk({"done_", nm},  64'(done32), 64'd1);
        chk({"lat_", nm},   64'(cyc - c0), 64'(elat));
        chk({"busyn_", nm}, 64'(nbusy), 64'(elat));
        chk({"lo_", nm},    64'(lo32), 64'(elo));
        chk({"hi_", nm},    64'(hi32), 64'(ehi));
        chk({"dbz_", nm},   64'(dbz32), 64'(edbz));
        chk({"ill_", nm},   64'(ill32), 64'(eill));
    endtask

    initial begin
        int c0;
        int r;
        rst32_n = 1'b0; start32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
        rst8_n  = 1'b0; start8  = 1'b0; op8  = '0; a8  = '0; b8  = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy32", 64'(busy32), 64'd0);
        chk("rst_done32", 64'(done32), 64'd0);
        chk("rst_lo32",   64'(lo32),   64'd0);
        chk("rst_hi32",   64'(hi32),   64'd0);
        rst32_n = 1'b1;
        rst8_n  = 1'b1;

        run32("and",    OP_AND, 32'hF0F0_00FF, 32'h0FF0_FF0F, 32'h00F0_000F, 32'h0, 0, 0, 1);
        run32("mul",    OP_MUL, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFEB, 32'hFFFF_FFFF, 0, 0, 34);
        run32("div",    OP_DIV, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, 0, 34);
        run32("dbz",    OP_DIV, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5, 1, 0, 1);
        run32("ror",    OP_ROR, 32'h8000_0001, 32'd1,         32'hC000_0000, 32'h0, 0, 0, 1);
        run32("sra",    OP_SRA, 32'h8000_0000, 32'd31,        32'hFFFF_FFFF, 32'h0, 0, 0, 1);
        run32("add",    OP_ADD, 32'hFFFF_FFFF, 32'd1,         32'h0,         32'h1, 0, 0, 1);
        run32("divmn",  OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 0, 0, 34);
        run32("sub",    OP_SUB, 32'd3,         32'd5,         32'hFFFF_FFFE, 32'h1, 0, 0, 1);
        run32("shl0",   OP_SHL, 32'h1234_5678, 32'h20,        32'h1234_5678, 32'h0, 0, 0, 1);
        run32("rol",    OP_ROL, 32'h8000_0001, 32'd4,         32'h0000_0018, 32'h0, 0, 0, 1);
        run32("mulmn",  OP_MUL, 32'h8000_0000, 32'h8000_0000, 32'h0,         32'h4000_0000, 0, 0, 34);
        run32("ill",    4'hF,   32'd1,         32'd2,         32'h0,         32'h0, 0, 1, 1);
        run32("not",    OP_NOT, 32'h0F0F_0F0F, 32'd0,         32'hF0F0_F0F0, 32'h0, 0, 0, 1);
        run32("neg",    OP_NEG, 32'd1,         32'd0,         32'hFFFF_FFFF, 32'h0, 0, 0, 1);
        run32("shr",    OP_SHR, 32'h8000_0000, 32'd4,         32'h0800_0000, 32'h0, 0, 0, 1);
        run32("divpn",  OP_DIV, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h1, 0, 0, 34);
        run32("divnn",  OP_DIV, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'h2,         32'hFFFF_FFFE, 0, 0, 34);

        // Reset in the middle of a multiply, with a start that must be dropped
        @(negedge clk);
        start32 = 1'b1; op32 = OP_MUL; a32 = 32'hFFFF_FFFD; b32 = 32'd7; c0 = cyc;
        @(negedge clk);
        start32 = 1'b0;
        while (cyc < c0 + 10) @(negedge clk);
        rst32_n = 1'b0; start32 = 1'b1; op32 = OP_ADD;
        @(negedge clk);
        chk("abort_busy", 64'(busy32), 64'd0);
        chk("abort_done", 64'(done32), 64'd0);
        chk("abort_lo",   64'(lo32),   64'd0);
        chk("abort_hi",   64'(hi32),   64'd0);
        rst32_n = 1'b1; start32 = 1'b0;
        run32("mul2",   OP_MUL, 32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 0, 0, 34);

        // Random WIDTH=8 sweep: back-to-back, ignored starts, rare resets
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst8_n = ($urandom_range(0, 599) != 0);
            start8 = 1'($urandom_range(0, 1));
            r = int'($urandom_range(0, 9));
            op8 = (r < 2) ? OP_MUL : (r < 4) ? OP_DIV : 4'($urandom);
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            case ($urandom_range(0, 7))
                0: b8 = 8'h00;
                1: begin a8 = 8'h80; b8 = 8'hFF; end
                2: b8 = 8'($urandom_range(0, 8));
                default: ;
            endcase
        end
        start8 = 1'b0;
        rst8_n = 1'b1;
        repeat (20) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
